// File: rtl/mb_bus_arbiter_if.sv
// Master/bus side signals of the peripheral-bus arbiter, grouped for port use.
// slave is the arbiter's view; master is the view of whoever drives requests and answers the bus.
interface mb_bus_arbiter_if #(
    parameter int NUM_M = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
);
    logic [NUM_M-1:0]    m_req;
    logic [NUM_M-1:0]    m_we;
    logic [NUM_M*AW-1:0] m_addr;
    logic [NUM_M*DW-1:0] m_wdata;
    logic [NUM_M-1:0]    m_ack;
    logic                m_err;
    logic [DW-1:0]       m_rdata;

    logic                bus_valid;
    logic                bus_we;
    logic [AW-1:0]       bus_addr;
    logic [DW-1:0]       bus_wdata;
    logic                bus_ready;
    logic [DW-1:0]       bus_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, bus_ready, bus_rdata,
        output m_ack, m_err, m_rdata, bus_valid, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, bus_ready, bus_rdata,
        input  m_ack, m_err, m_rdata, bus_valid, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mb_bus_arbiter.sv
// Round-robin arbiter serialising NUM_M masters onto one bus port; >=3 cycles per transaction.
// bus_* held until bus_ready; a watchdog aborts after TIMEOUT stalled cycles with m_err.
module mb_bus_arbiter #(
    parameter int NUM_M   = 4,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               RESET,
    mb_bus_arbiter_if.slave    bus_if,
    output logic [NUM_M-1:0]   grant,
    output logic               busy
);
    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   cnt;
    logic            any_req;
    logic [IW-1:0]   pick_idx;
    int              idx;

    // Scan downward so the final overwrite is the nearest requester after last.
    always_comb begin
        any_req  = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = NUM_M; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_M) begin
                idx = idx - NUM_M;
            end
            if (bus_if.m_req[idx]) begin
                any_req  = 1'b1;
                pick_idx = IW'(idx);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state            <= IDLE;
            last             <= IW'(NUM_M - 1);
            owner            <= '0;
            cnt              <= '0;
            grant            <= '0;
            busy             <= 1'b0;
            bus_if.bus_valid <= 1'b0;
            bus_if.bus_we    <= 1'b0;
            bus_if.bus_addr  <= '0;
            bus_if.bus_wdata <= '0;
            bus_if.m_ack     <= '0;
            bus_if.m_err     <= 1'b0;
            bus_if.m_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus_if.m_ack   <= '0;
                    bus_if.m_err   <= 1'b0;
                    bus_if.m_rdata <= '0;
                    if (any_req) begin
                        owner            <= pick_idx;
                        grant            <= NUM_M'(1) << pick_idx;
                        busy             <= 1'b1;
                        cnt              <= '0;
                        bus_if.bus_valid <= 1'b1;
                        bus_if.bus_we    <= bus_if.m_we[pick_idx];
                        bus_if.bus_addr  <= bus_if.m_addr[pick_idx*AW +: AW];
                        bus_if.bus_wdata <= bus_if.m_wdata[pick_idx*DW +: DW];
                        state            <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Ready takes precedence over a watchdog expiry in the same cycle.
                    if (bus_if.bus_ready) begin
                        bus_if.bus_valid <= 1'b0;
                        bus_if.m_ack     <= NUM_M'(1) << owner;
                        bus_if.m_err     <= 1'b0;
                        bus_if.m_rdata   <= bus_if.bus_we ? '0 : bus_if.bus_rdata;
                        state            <= ACK;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        bus_if.bus_valid <= 1'b0;
                        bus_if.m_ack     <= NUM_M'(1) << owner;
                        bus_if.m_err     <= 1'b1;
                        bus_if.m_rdata   <= '0;
                        state            <= ACK;
                    end
                end
                ACK: begin
                    bus_if.m_ack   <= '0;
                    bus_if.m_err   <= 1'b0;
                    bus_if.m_rdata <= '0;
                    last           <= owner;
                    grant          <= '0;
                    cnt            <= '0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mb_bus_arbiter.sv
// Directed bench for mb_bus_arbiter; acks are matched against a queue of expected completions.
module tb_mb_bus_arbiter;
    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  ack;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mb_bus_arbiter_if #(.NUM_M(4), .AW(16), .DW(32)) ifc ();

    mb_bus_arbiter #(.NUM_M(4), .AW(16), .DW(32), .TIMEOUT(8)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .bus_if (ifc.slave),
        .grant  (grant),
        .busy   (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] d, input logic e);
        exp_t x;
        x.ack   = a;
        x.rdata = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Advance one cycle, then match any acknowledge against the scoreboard.
    task automatic tick();
        exp_t x;
        @(posedge CLK);
        #1;
        if (ifc.m_ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ifc.m_ack), 32'h0);
            end else begin
                x = sb.pop_front();
                chk("sb_ack", 32'(ifc.m_ack), 32'(x.ack));
                chk("sb_rdata", ifc.m_rdata, x.rdata);
                chk("sb_err", 32'(ifc.m_err), 32'(x.err));
            end
        end
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        int n;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        ifc.m_req = '0; ifc.m_we = '0; ifc.m_addr = '0; ifc.m_wdata = '0;
        ifc.bus_ready = 1'b0; ifc.bus_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(ifc.bus_valid), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ifc.m_ack), 32'h0);
        chk("rst_rdata", ifc.m_rdata, 32'h0);
        RESET = 1'b0;

        // Single read, ready two cycles after valid
        ifc.m_req = 4'b0001;
        ifc.m_addr[0 +: 16] = 16'h0010;
        tick();
        chk("rd_valid", 32'(ifc.bus_valid), 32'h1);
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_addr", 32'(ifc.bus_addr), 32'h0010);
        chk("rd_we", 32'(ifc.bus_we), 32'h0);
        chk("rd_busy", 32'(busy), 32'h1);
        tick();
        chk("rd_wait_ack", 32'(ifc.m_ack), 32'h0);
        ifc.bus_ready = 1'b1;
        ifc.bus_rdata = 32'hDEADBEEF;
        push(4'b0001, 32'hDEADBEEF, 1'b0);
        tick();
        chk("rd_ack", 32'(ifc.m_ack), 32'h1);
        chk("rd_valid_drop", 32'(ifc.bus_valid), 32'h0);
        ifc.m_req = '0;
        ifc.bus_ready = 1'b0;
        tick();
        chk("rd_ack_clear", 32'(ifc.m_ack), 32'h0);
        chk("rd_grant_clear", 32'(grant), 32'h0);
        chk("rd_busy_clear", 32'(busy), 32'h0);

        // Round-robin with all requesting and ready tied high
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        ifc.m_req = 4'b1111;
        ifc.bus_ready = 1'b1;
        ifc.bus_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
            push(rr_exp[i], 32'hCAFEF00D, 1'b0);
            tick();
            chk("rr_ack", 32'(ifc.m_ack), 32'(rr_exp[i]));
            tick();
            chk("rr_gap", 32'(ifc.m_ack), 32'h0);
        end
        ifc.m_req = '0;
        ifc.bus_ready = 1'b0;

        // Write held stable through a delayed ready
        ifc.m_req = 4'b0100;
        ifc.m_we = 4'b0100;
        ifc.m_addr[32 +: 16] = 16'h00A4;
        ifc.m_wdata[64 +: 32] = 32'h12345678;
        ifc.bus_rdata = 32'hFFFFFFFF;
        tick();
        chk("wr_grant", 32'(grant), 32'h4);
        for (int i = 0; i < 5; i++) begin
            chk("wr_valid", 32'(ifc.bus_valid), 32'h1);
            chk("wr_we", 32'(ifc.bus_we), 32'h1);
            chk("wr_addr", 32'(ifc.bus_addr), 32'h00A4);
            chk("wr_wdata", ifc.bus_wdata, 32'h12345678);
            tick();
        end
        ifc.bus_ready = 1'b1;
        push(4'b0100, 32'h0, 1'b0);
        tick();
        chk("wr_ack", 32'(ifc.m_ack), 32'h4);
        ifc.m_req = '0; ifc.m_we = '0; ifc.bus_ready = 1'b0;
        tick();

        // Watchdog timeout with ready never arriving
        ifc.m_req = 4'b0001;
        ifc.m_addr[0 +: 16] = 16'h0020;
        ifc.bus_rdata = 32'h11111111;
        push(4'b0001, 32'h0, 1'b1);
        tick();
        n = 0;
        for (int i = 0; i < 20 && ifc.bus_valid === 1'b1; i++) begin
            n++;
            tick();
        end
        chk("to_valid_cycles", 32'(n), 32'd8);
        chk("to_ack", 32'(ifc.m_ack), 32'h1);
        chk("to_err", 32'(ifc.m_err), 32'h1);
        chk("to_rdata", ifc.m_rdata, 32'h0);
        ifc.m_req = '0;
        tick();

        // Ready coincident with the last watchdog cycle
        ifc.m_req = 4'b0001;
        tick();
        repeat (7) tick();
        chk("co_valid", 32'(ifc.bus_valid), 32'h1);
        ifc.bus_ready = 1'b1;
        ifc.bus_rdata = 32'h0BADF00D;
        push(4'b0001, 32'h0BADF00D, 1'b0);
        tick();
        chk("co_ack", 32'(ifc.m_ack), 32'h1);
        chk("co_err", 32'(ifc.m_err), 32'h0);
        ifc.m_req = '0; ifc.bus_ready = 1'b0;
        tick();

        // Reset in BUSY drops the transaction without an ack
        ifc.m_req = 4'b0100;
        ifc.m_we = '0;
        tick();
        tick();
        chk("mr_busy", 32'(busy), 32'h1);
        RESET = 1'b1;
        tick();
        chk("mr_valid", 32'(ifc.bus_valid), 32'h0);
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_ack", 32'(ifc.m_ack), 32'h0);
        RESET = 1'b0;
        ifc.m_req = 4'b1010;
        tick();
        chk("mr_grant1", 32'(grant), 32'h2);
        ifc.bus_ready = 1'b1;
        ifc.bus_rdata = 32'h22222222;
        push(4'b0010, 32'h22222222, 1'b0);
        tick();
        ifc.m_req = 4'b1000;
        tick();
        tick();
        chk("mr_grant3", 32'(grant), 32'h8);
        push(4'b1000, 32'h22222222, 1'b0);
        tick();
        ifc.m_req = '0; ifc.bus_ready = 1'b0;
        tick();

        // Priority immediately after reset
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        ifc.m_req = 4'b1001;
        ifc.bus_ready = 1'b1;
        ifc.bus_rdata = 32'h33333333;
        tick();
        chk("pr_grant0", 32'(grant), 32'h1);
        push(4'b0001, 32'h33333333, 1'b0);
        tick();
        ifc.m_req = 4'b1000;
        tick();
        tick();
        chk("pr_grant3", 32'(grant), 32'h8);
        push(4'b1000, 32'h33333333, 1'b0);
        tick();
        ifc.m_req = '0; ifc.bus_ready = 1'b0;
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
